char_writer: RTL and testbench

- Upstream stage of the 1kx8 character buffer (16 lines x 64 columns). Consumes the host byte stream (from the UART receiver) and interprets a VT52 subset: printable characters, control codes and ESC sequences.
- Produces one-byte-per-cycle writes into the buffer's write port.
- Maintains the cursor position and a hardware-scroll line offset (first_line) for the video reader.

---
 rtl/char_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_char_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_writer.sv
// char_writer: VT52-subset front end for the 16x64 character buffer.
// It takes host bytes and turns them into one-byte-per-cycle buffer writes.
// It tracks the cursor and a hardware-scroll offset (first_line) for the video reader.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   data_in/data_valid  incoming byte stream
//   ready               byte is taken when data_valid && ready
//   buf_waddr/din/we    buffer write port, addr = {phys_row, col}
//   cursor_x/cursor_y   cursor column 0..63 and logical row 0..15
//   first_line          physical row displayed as logical row 0
module char_writer #(
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic [9:0] buf_waddr,
    output logic [7:0] buf_din,
    output logic       buf_we,
    output logic [5:0] cursor_x,
    output logic [3:0] cursor_y,
    output logic [3:0] first_line
);

    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned ADDR_W = ROW_W + COL_W;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(63);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC,
        S_ESC_Y_ROW,
        S_ESC_Y_COL,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0]  clr_end_q, clr_end_d;

    logic [COL_W-1:0]   x_d;
    logic [ROW_W-1:0]   y_d;
    logic [ROW_W-1:0]   fl_d;
    logic               ready_d;
    logic [ADDR_W-1:0]  waddr_d;
    logic [7:0]         din_d;
    logic               we_d;

    logic               accept;
    logic [ROW_W-1:0]   phys_cur;
    logic [6:0]         tab_sum;
    logic [COL_W-1:0]   tab_x;
    logic [7:0]         yoff;
    logic [ROW_W-1:0]   row_sat;
    logic [COL_W-1:0]   col_sat;

    // Byte-derived helpers: tab stop and saturated ESC Y coordinates.
    always_comb begin
        accept   = data_valid && (state_q != S_CLEAR);
        phys_cur = cursor_y + first_line;
        tab_sum  = {1'b0, cursor_x | COL_W'(7)} + 7'd1;
        tab_x    = tab_sum[6] ? COL_MAX : tab_sum[5:0];
        yoff     = data_in - 8'h20;
        if (data_in < 8'h20) begin
            row_sat = '0;
            col_sat = '0;
        end else begin
            row_sat = (yoff > 8'd15) ? ROW_MAX : yoff[3:0];
            col_sat = (yoff > 8'd63) ? COL_MAX : yoff[5:0];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        clr_addr_d = clr_addr_q;
        clr_end_d  = clr_end_q;
        x_d        = cursor_x;
        y_d        = cursor_y;
        fl_d       = first_line;
        we_d       = 1'b0;
        waddr_d    = buf_waddr;
        din_d      = buf_din;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (data_in >= 8'h20 && data_in <= 8'h7E) begin
                        we_d    = 1'b1;
                        waddr_d = {phys_cur, cursor_x};
                        din_d   = data_in;
                        if (cursor_x != COL_MAX) x_d = cursor_x + COL_W'(1);
                    end else begin
                        case (data_in)
                            8'h0D: x_d = '0;
                            8'h0A: begin
                                if (cursor_y != ROW_MAX) begin
                                    y_d = cursor_y + ROW_W'(1);
                                end else begin
                                    // Scroll up: bottom logical row now maps to the old top row.
                                    fl_d       = first_line + ROW_W'(1);
                                    clr_addr_d = {ROW_MAX, COL_W'(0)};
                                    clr_end_d  = {ROW_MAX, COL_MAX};
                                    state_d    = S_CLEAR;
                                end
                            end
                            8'h08: if (cursor_x != '0) x_d = cursor_x - COL_W'(1);
                            8'h09: x_d = tab_x;
                            8'h1B: state_d = S_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            S_ESC: begin
                if (accept) begin
                    state_d = S_IDLE;
                    case (data_in)
                        8'h41: if (cursor_y != '0) y_d = cursor_y - ROW_W'(1);
                        8'h42: if (cursor_y != ROW_MAX) y_d = cursor_y + ROW_W'(1);
                        8'h43: if (cursor_x != COL_MAX) x_d = cursor_x + COL_W'(1);
                        8'h44: if (cursor_x != '0) x_d = cursor_x - COL_W'(1);
                        8'h48: begin
                            x_d = '0;
                            y_d = '0;
                        end
                        8'h49: begin
                            if (cursor_y != '0) begin
                                y_d = cursor_y - ROW_W'(1);
                            end else begin
                                // Scroll down: blank the row that becomes logical row 0.
                                fl_d       = first_line - ROW_W'(1);
                                clr_addr_d = {ROW_W'(0), COL_W'(0)};
                                clr_end_d  = {ROW_W'(0), COL_MAX};
                                state_d    = S_CLEAR;
                            end
                        end
                        8'h4A: begin
                            clr_addr_d = {cursor_y, cursor_x};
                            clr_end_d  = {ROW_MAX, COL_MAX};
                            state_d    = S_CLEAR;
                        end
                        8'h4B: begin
                            clr_addr_d = {cursor_y, cursor_x};
                            clr_end_d  = {cursor_y, COL_MAX};
                            state_d    = S_CLEAR;
                        end
                        8'h59: state_d = S_ESC_Y_ROW;
                        default: ;
                    endcase
                end
            end

            S_ESC_Y_ROW: begin
                if (accept) begin
                    row_d   = row_sat;
                    state_d = S_ESC_Y_COL;
                end
            end

            S_ESC_Y_COL: begin
                if (accept) begin
                    y_d     = row_q;
                    x_d     = col_sat;
                    state_d = S_IDLE;
                end
            end

            S_CLEAR: begin
                // Logical counter; physical row follows the current scroll offset.
                we_d    = 1'b1;
                waddr_d = {clr_addr_q[ADDR_W-1:COL_W] + first_line, clr_addr_q[COL_W-1:0]};
                din_d   = FILL_CHAR;
                if (clr_addr_q == clr_end_q) begin
                    state_d = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d != S_CLEAR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            ready      <= !CLEAR_ON_RESET;
            row_q      <= '0;
            clr_addr_q <= '0;
            clr_end_q  <= '1;
            cursor_x   <= '0;
            cursor_y   <= '0;
            first_line <= '0;
            buf_we     <= 1'b0;
            buf_waddr  <= '0;
            buf_din    <= '0;
        end else begin
            state_q    <= state_d;
            ready      <= ready_d;
            row_q      <= row_d;
            clr_addr_q <= clr_addr_d;
            clr_end_q  <= clr_end_d;
            cursor_x   <= x_d;
            cursor_y   <= y_d;
            first_line <= fl_d;
            buf_we     <= we_d;
            buf_waddr  <= waddr_d;
            buf_din    <= din_d;
        end
    end

endmodule

// File: tb/tb_char_writer.sv
// Directed bench for char_writer: expected buffer writes are queued as bytes are
// driven and matched against buf_* whenever buf_we is seen.
module tb_char_writer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       ready;
    logic [9:0] buf_waddr;
    logic [7:0] buf_din;
    logic       buf_we;
    logic [5:0] cursor_x;
    logic [3:0] cursor_y;
    logic [3:0] first_line;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    localparam int LIMIT = 5000;

    char_writer #(.FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .buf_waddr  (buf_waddr),
        .buf_din    (buf_din),
        .buf_we     (buf_we),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .first_line (first_line)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write: got addr %h din %h expected none", buf_waddr, buf_din);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                assert ({buf_waddr, buf_din} === e) else begin
                    errors++;
                    $error("FAIL write: got addr %h din %h expected addr %h din %h",
                           buf_waddr, buf_din, e[17:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_row(input logic [3:0] prow);
        for (int c = 0; c < 64; c++) push({prow, 6'(c)}, 8'h20);
    endtask

    // Present a byte, hold it until ready, check buf_we in the cycle after acceptance.
    task automatic send(input logic [7:0] b, input logic exp_we, output int waited);
        waited = 0;
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        while (ready !== 1'b1 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= LIMIT) chk("accept_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        #1 data_valid = 1'b0;
        @(negedge clk);
        chk("we_after_accept", 32'(buf_we), 32'(exp_we));
    endtask

    task automatic s(input logic [7:0] b, input logic exp_we);
        int w;
        send(b, exp_we, w);
    endtask

    // Called at a negedge; counts negedges until ready is seen high.
    task automatic wait_idle(output int n);
        n = 0;
        while (ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int jcnt;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cx", 32'(cursor_x), 32'd0);
        chk("rst_cy", 32'(cursor_y), 32'd0);
        chk("rst_fl", 32'(first_line), 32'd0);
        chk("rst_we", 32'(buf_we), 32'd0);
        chk("rst_waddr", 32'(buf_waddr), 32'd0);
        chk("rst_din", 32'(buf_din), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);

        // Power-on clear of all 1024 locations.
        for (int a = 0; a < 1024; a++) push(10'(a), 8'h20);
        reset_n = 1'b1;
        wait_idle(n);
        chk("por_clear_cycles", 32'(n), 32'd1024);
        @(negedge clk);
        chk("por_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("por_cx", 32'(cursor_x), 32'd0);
        chk("por_cy", 32'(cursor_y), 32'd0);

        // Printable characters.
        push(10'h000, 8'h41); s(8'h41, 1'b1);
        push(10'h001, 8'h42); s(8'h42, 1'b1);
        chk("ab_cx", 32'(cursor_x), 32'd2);

        // Direct cursor addressing.
        s(8'h1B, 1'b0); s(8'h59, 1'b0); s(8'h25, 1'b0); s(8'h2A, 1'b0);
        chk("escy_cy", 32'(cursor_y), 32'd5);
        chk("escy_cx", 32'(cursor_x), 32'd10);
        push(10'h14A, 8'h5A); s(8'h5A, 1'b1);
        chk("z_cx", 32'(cursor_x), 32'd11);
        s(8'h1B, 1'b0); s(8'h59, 1'b0); s(8'h7F, 1'b0); s(8'h7F, 1'b0);
        chk("escy_sat_cy", 32'(cursor_y), 32'd15);
        chk("escy_sat_cx", 32'(cursor_x), 32'd63);
        s(8'h0D, 1'b0);
        chk("cr_cx", 32'(cursor_x), 32'd0);

        // LF on bottom row scrolls; next byte is held through the clear.
        push_row(4'd0);
        s(8'h0A, 1'b0);
        chk("lf_fl", 32'(first_line), 32'd1);
        chk("lf_ready", 32'(ready), 32'd0);
        push(10'h000, 8'h51);
        send(8'h51, 1'b1, n);
        chk("lf_hold_wait", 32'(n), 32'd63);
        chk("lf_cy", 32'(cursor_y), 32'd15);
        chk("q_cx", 32'(cursor_x), 32'd1);

        // Two more scrolls bring first_line to 3.
        push_row(4'd1); s(8'h0A, 1'b0);
        push_row(4'd2); s(8'h0A, 1'b0);
        wait_idle(n);
        chk("fl3", 32'(first_line), 32'd3);

        // ESC K and ESC J from (2,60) with first_line=3.
        s(8'h1B, 1'b0); s(8'h59, 1'b0); s(8'h22, 1'b0); s(8'h5C, 1'b0);
        for (int c = 60; c < 64; c++) push({4'd5, 6'(c)}, 8'h20);
        s(8'h1B, 1'b0); s(8'h4B, 1'b0);
        wait_idle(n);
        chk("esck_count", 32'(n), 32'd4);
        jcnt = 0;
        for (int c = 60; c < 64; c++) begin push({4'd5, 6'(c)}, 8'h20); jcnt++; end
        for (int r = 3; r < 16; r++) begin
            for (int c = 0; c < 64; c++) begin
                push({4'(r + 3), 6'(c)}, 8'h20);
                jcnt++;
            end
        end
        s(8'h1B, 1'b0); s(8'h4A, 1'b0);
        wait_idle(n);
        chk("escj_count", 32'(n), 32'(jcnt));
        chk("escj_cy", 32'(cursor_y), 32'd2);
        chk("escj_cx", 32'(cursor_x), 32'd60);
        @(negedge clk);
        chk("escj_queue_empty", 32'(exp_q.size()), 32'd0);

        // Home, tab, backspace, ESC A/B/C/D.
        s(8'h1B, 1'b0); s(8'h48, 1'b0);
        s(8'h09, 1'b0); chk("tab1", 32'(cursor_x), 32'd8);
        s(8'h09, 1'b0); chk("tab2", 32'(cursor_x), 32'd16);
        s(8'h08, 1'b0); chk("bs", 32'(cursor_x), 32'd15);
        s(8'h1B, 1'b0); s(8'h42, 1'b0); chk("esc_b", 32'(cursor_y), 32'd1);
        s(8'h1B, 1'b0); s(8'h43, 1'b0); chk("esc_c", 32'(cursor_x), 32'd16);
        s(8'h1B, 1'b0); s(8'h41, 1'b0); chk("esc_a", 32'(cursor_y), 32'd0);
        s(8'h1B, 1'b0); s(8'h44, 1'b0); chk("esc_d", 32'(cursor_x), 32'd15);
        s(8'h1B, 1'b0); s(8'h48, 1'b0);

        // Reverse LF on top row scrolls down.
        push_row(4'd2);
        s(8'h1B, 1'b0); s(8'h49, 1'b0);
        wait_idle(n);
        chk("esci_count", 32'(n), 32'd64);
        chk("esci_fl", 32'(first_line), 32'd2);
        chk("esci_cy", 32'(cursor_y), 32'd0);

        // Ignored bytes, including ESC ESC.
        s(8'h01, 1'b0);
        s(8'h1B, 1'b0); s(8'h1B, 1'b0);
        push(10'h080, 8'h21); s(8'h21, 1'b1);
        chk("ign_cx", 32'(cursor_x), 32'd1);

        // Saturation at column 63: last two writes land on col 63.
        s(8'h1B, 1'b0); s(8'h59, 1'b0); s(8'h23, 1'b0); s(8'h20, 1'b0);
        for (int i = 0; i < 65; i++) begin
            push({4'd5, (i > 63) ? 6'd63 : 6'(i)}, 8'h21 + 8'(i));
            s(8'h21 + 8'(i), 1'b1);
        end
        chk("sat_cx", 32'(cursor_x), 32'd63);

        // Reset during a clear stops it; power-on clear restarts.
        s(8'h1B, 1'b0); s(8'h48, 1'b0);
        for (int c = 0; c < 10; c++) push({4'd2, 6'(c)}, 8'h20);
        s(8'h1B, 1'b0); s(8'h4A, 1'b0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", 32'(buf_we), 32'd0);
        chk("mid_rst_fl", 32'(first_line), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < 1024; a++) push(10'(a), 8'h20);
        reset_n = 1'b1;
        wait_idle(n);
        chk("mid_rst_clear_cycles", 32'(n), 32'd1024);
        @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
